// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_feeder
// Description : Byte FIFO in front of a UART transmitter. A producer pushes
//               bytes with a VALID/READY handshake; a three-state sequencer
//               pops one byte at a time, pulses TX_START_O for one cycle and
//               then waits for TX_DONE_I before fetching the next byte.
//
// Ports       : CLK_I       clock, all state updates on the rising edge
//               RST_I       synchronous active-high reset
//               DATA_I      byte to enqueue
//               VALID_I     producer offers DATA_I this cycle
//               READY_O     FIFO has room (write when VALID_I && READY_O)
//               TX_START_O  one-cycle start pulse to the transmitter
//               TX_DATA_O   byte presented to the transmitter
//               TX_DONE_I   one-cycle frame-finished pulse from transmitter
//               FILL_O      bytes stored, excluding the byte in flight
//               EMPTY_O     FILL_O == 0
//               BUSY_O      sequencer not idle
//
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_feeder #(
    parameter int DEPTH = 8
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic [7:0]               DATA_I,
    input  logic                     VALID_I,
    output logic                     READY_O,
    output logic                     TX_START_O,
    output logic [7:0]               TX_DATA_O,
    input  logic                     TX_DONE_I,
    output logic [$clog2(DEPTH):0]   FILL_O,
    output logic                     EMPTY_O,
    output logic                     BUSY_O
);

    localparam int               PW      = $clog2(DEPTH);
    localparam int               CW      = PW + 1;
    localparam logic [CW-1:0]    c_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fill_q,   fill_d;
    logic [7:0]    tx_data_q, tx_data_d;
    state_t        state_q,  state_d;

    logic          w_push;
    logic          w_pop;
    logic          w_tx_start;

    // Ready depends only on the registered count, so a producer never sees
    // a combinational path from the sequencer's pop decision.
    assign READY_O = (fill_q < c_DEPTH);
    assign w_push  = VALID_I && READY_O;

    // Pop uses the registered count: a byte written into an empty FIFO on
    // this edge is not visible to the sequencer until the next edge.
    assign w_pop   = (state_q == ST_IDLE) && (fill_q != '0);

    // ------------------------------------------------------------------
    // FIFO next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        tx_data_d = tx_data_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (w_pop) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            tx_data_d = mem_q[rd_ptr_q];
        end

        case ({w_push, w_pop})
            2'b10:   fill_d = fill_q + CW'(1);
            2'b01:   fill_d = fill_q - CW'(1);
            default: fill_d = fill_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        w_tx_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_pop) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // TX_DONE_I is deliberately ignored here.
                w_tx_start = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (TX_DONE_I) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            tx_data_q <= 8'h00;
            state_q   <= ST_IDLE;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            tx_data_q <= tx_data_d;
            state_q   <= state_d;
        end
    end

    // Storage array has no reset; contents behind the pointers are don't-care.
    always_ff @(posedge CLK_I) begin
        if (w_push && !RST_I) begin
            mem_q[wr_ptr_q] <= DATA_I;
        end
    end

    assign TX_START_O = w_tx_start;
    assign TX_DATA_O  = tx_data_q;
    assign FILL_O     = fill_q;
    assign EMPTY_O    = (fill_q == '0);
    assign BUSY_O     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_feeder
// Description : Self-checking bench for uart_tx_feeder. Accepted bytes are
//               pushed into a scoreboard queue; a monitor pops and compares
//               on every TX_START_O. A queue-based reference model predicts
//               the flag outputs each cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_feeder;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK_I = 1'b0;
    logic          RST_I = 1'b1;
    logic [7:0]    DATA_I = 8'h00;
    logic          VALID_I = 1'b0;
    logic          READY_O;
    logic          TX_START_O;
    logic [7:0]    TX_DATA_O;
    logic          TX_DONE_I = 1'b0;
    logic [CW-1:0] FILL_O;
    logic          EMPTY_O;
    logic          BUSY_O;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .DATA_I     (DATA_I),
        .VALID_I    (VALID_I),
        .READY_O    (READY_O),
        .TX_START_O (TX_START_O),
        .TX_DATA_O  (TX_DATA_O),
        .TX_DONE_I  (TX_DONE_I),
        .FILL_O     (FILL_O),
        .EMPTY_O    (EMPTY_O),
        .BUSY_O     (BUSY_O)
    );

    always #5 CLK_I = ~CLK_I;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: bytes accepted and not yet started.
    logic [7:0] exp_q[$];

    // Reference model: stored bytes, frame phase (0 idle, 1 start pulse,
    // 2 frame on the wire) and the byte presented to the transmitter.
    logic [7:0] mq[$];
    int         mphase = 0;
    logic [7:0] mcur   = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every start pulse must present the oldest outstanding byte.
    always @(negedge CLK_I) begin
        if (TX_START_O === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL start_unexpected: got byte %0h expected no start at %0t", TX_DATA_O, $time);
            end else begin
                chk("start_byte", 32'(TX_DATA_O), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock cycle: drive inputs just after the edge, check outputs and
    // advance the model at the falling edge, return just after the next edge.
    task automatic step(input logic v, input logic [7:0] d, input logic dn,
                        input logic rst, output bit acc);
        bit pop;
        VALID_I   = v;
        DATA_I    = d;
        TX_DONE_I = dn;
        RST_I     = rst;
        @(negedge CLK_I);
        chk("ready",    32'(READY_O),    32'(mq.size() < DEPTH));
        chk("fill",     32'(FILL_O),     32'(mq.size()));
        chk("empty",    32'(EMPTY_O),    32'(mq.size() == 0));
        chk("busy",     32'(BUSY_O),     32'(mphase != 0));
        chk("tx_start", 32'(TX_START_O), 32'(mphase == 1));
        chk("tx_data",  32'(TX_DATA_O),  32'(mcur));
        acc = 1'b0;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            mphase = 0;
            mcur   = 8'h00;
        end else begin
            acc = v && (mq.size() < DEPTH);
            pop = (mphase == 0) && (mq.size() > 0);
            if (pop) begin
                mcur   = mq.pop_front();
                mphase = 1;
            end else if (mphase == 1) begin
                mphase = 2;
            end else if (mphase == 2 && dn) begin
                mphase = 0;
            end
            if (acc) begin
                mq.push_back(d);
                exp_q.push_back(d);
            end
        end
        @(posedge CLK_I);
        #1;
    endtask

    // Autonomous traffic: pv = percent chance to offer a byte, dly = cycles
    // from start pulse to done (0 = random 1..6), limit = max bytes to
    // accept (-1 unlimited), spur = random done pulses outside a frame.
    task automatic auto(input int ncyc, input int pv, input int dly,
                        input int limit, input bit spur, output int sent);
        int  sc;
        int  dd;
        bit  v;
        bit  dn;
        bit  acc;
        sc   = 0;
        dd   = (dly == 0) ? 3 : dly;
        sent = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (mphase == 1) begin
                sc = 0;
                if (dly == 0) dd = $urandom_range(1, 6);
            end else if (mphase == 2) begin
                sc++;
            end
            v  = ((limit < 0) || (sent < limit)) && ($urandom_range(0, 99) < pv);
            dn = ((mphase == 2) && (sc == dd)) ||
                 (spur && (mphase != 2) && ($urandom_range(0, 7) == 0));
            step(v, 8'($urandom), dn, 1'b0, acc);
            if (acc) sent++;
        end
    endtask

    task automatic drained(input string nm);
        chk({nm, "_sb_empty"},    32'(exp_q.size()), 32'd0);
        chk({nm, "_model_empty"}, 32'(mq.size()),    32'd0);
        chk({nm, "_idle"},        32'(mphase),       32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int sent;
        @(posedge CLK_I);
        #1;

        // Reset values
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);

        // Single byte A5
        step(1'b1, 8'hA5, 1'b0, 1'b0, acc);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        drained("single");

        // Fill to full: 00..09 with done held low, 09 dropped
        for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b0, 1'b0, acc);
        chk("full_fill", 32'(FILL_O), 32'd8);
        chk("full_ready", 32'(READY_O), 32'd0);
        auto(200, 0, 3, 0, 1'b0, sent);
        drained("full");

        // Simultaneous write and pop with three stored
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        step(1'b1, 8'h77, 1'b0, 1'b0, acc);
        chk("simul_fill", 32'(FILL_O), 32'd3);
        auto(200, 0, 2, 0, 1'b0, sent);
        drained("simul");

        // Spurious done in idle and in start
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        step(1'b1, 8'h3C, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        drained("spur");

        // Reset mid-frame with four queued, then a late done
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        drained("rst_mid");

        // Wrap-around: 3*DEPTH bytes, done 5 cycles after each start
        auto(400, 100, 5, 3 * DEPTH, 1'b0, sent);
        chk("wrap_count", 32'(sent), 32'(3 * DEPTH));
        drained("wrap");

        // Random traffic with random frame lengths and stray done pulses
        auto(600, 60, 0, -1, 1'b1, sent);
        auto(400, 0, 0, 0, 1'b0, sent);
        drained("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 8: FIFO depth in bytes; SHALL be a power of two, >= 2.
REQ-002 Port CLK_I  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port RST_I  input  1  reset; synchronous, active-high.
REQ-004 Port DATA_I  input  8  byte to enqueue.
REQ-005 Port VALID_I  input  1  producer offers DATA_I this cycle.
REQ-006 Port READY_O  output  1  FIFO can accept; write occurs on an edge where VALID_I && READY_O.
REQ-007 Port TX_START_O  output  1  one-cycle start pulse to the UART transmitter.
REQ-008 Port TX_DATA_O  output  8  byte presented to the UART transmitter.
REQ-009 Port TX_DONE_I  input  1  one-cycle pulse from the UART transmitter: frame (stop bit) finished.
REQ-010 Port FILL_O  output  $clog2(DEPTH)+1  number of bytes stored, excluding the byte in flight.
REQ-011 Port EMPTY_O  output  1  FILL_O == 0.
REQ-012 Port BUSY_O  output  1  sequencer not in ST_IDLE.

Function
REQ-013 Storage SHALL be a DEPTH-entry circular buffer with read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus a fill counter.
REQ-014 READY_O SHALL equal (FILL_O < DEPTH), combinational from registered state only; no dependence on a same-cycle pop.
REQ-015 Write when full (VALID_I high, READY_O low): data SHALL be dropped; pointers and count unchanged.
REQ-016 Simultaneous write and pop on one edge: both SHALL take effect; FILL_O unchanged; a write into an empty FIFO SHALL NOT be popped on the same edge.
REQ-017 Sequencer SHALL have three states: ST_IDLE, ST_START, ST_WAIT.
REQ-018 ST_IDLE: if FILL_O > 0, pop head into TX_DATA_O register and go to ST_START; else remain.
REQ-019 ST_START: TX_START_O = 1 (decoded from state, exactly one cycle); next state ST_WAIT unconditionally.
REQ-020 ST_WAIT: on TX_DONE_I = 1 go to ST_IDLE; else remain; no timeout.
REQ-021 TX_START_O SHALL be 0 in all states other than ST_START.
REQ-022 TX_DATA_O SHALL change only on the pop edge and stay stable through ST_START and ST_WAIT.
REQ-023 TX_DONE_I in ST_IDLE or ST_START SHALL be ignored without state change.
REQ-024 Latency: byte written at edge k into an empty FIFO with sequencer idle -> TX_START_O high in the cycle after edge k+1.
REQ-025 Back-to-back: after TX_DONE_I at edge m, with FIFO non-empty, the next TX_START_O SHALL be high in the cycle after edge m+1 (one ST_IDLE cycle between frames).
REQ-026 Bytes SHALL be transmitted in write order; none lost or duplicated while READY_O is honoured.

Reset
REQ-027 RST_I high at a rising edge SHALL clear pointers and count, set state ST_IDLE, and set TX_DATA_O = 8'h00, overriding any same-edge write or pop.
REQ-028 Output values during/after reset: READY_O=1, TX_START_O=0, FILL_O=0, EMPTY_O=1, BUSY_O=0.
REQ-029 Reset mid-frame (ST_WAIT) SHALL discard the in-flight byte and all queued bytes; a later TX_DONE_I from the old frame SHALL be ignored (REQ-023).

Verification
REQ-030 Single byte: write 8'hA5 to empty FIFO at edge k -> TX_START_O high after edge k+1 for one cycle, TX_DATA_O=8'hA5 until TX_DONE_I; BUSY_O drops one edge after TX_DONE_I.
REQ-031 Fill to full: DEPTH=8, write 10 bytes 8'h00..8'h09 with TX_DONE_I held low -> 8'h00 in flight, FILL_O reaches 8 with READY_O=0, 8'h09 dropped; draining yields 8'h00..8'h08 in order.
REQ-032 Simultaneous: FILL_O=3, write on the same edge as a pop -> FILL_O stays 3; written byte emitted fourth afterward.
REQ-033 Spurious done: TX_DONE_I pulsed in ST_IDLE (empty) and in ST_START -> no state change, no extra TX_START_O.
REQ-034 Reset mid-frame: 4 bytes queued, RST_I high during ST_WAIT -> all outputs at REQ-028 values next cycle; late TX_DONE_I causes no TX_START_O.
REQ-035 Wrap-around: 3*DEPTH bytes streamed with TX_DONE_I 5 cycles after each TX_START_O -> output sequence equals input sequence exactly.
